// File: rtl/mod_div_pkg.sv
// ============================================================================
// Module  : mod_div_pkg
// Purpose : Shared types and helpers for the restoring divider unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mod_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DBZ_MAX_WIDTH = 128;

    // All-ones quotient reported on divide-by-zero; callers cast to their width.
    function automatic logic [DBZ_MAX_WIDTH-1:0] DBZ_QUOTIENT(input int width);
        logic [DBZ_MAX_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < DBZ_MAX_WIDTH; i++) begin
            if (i < width) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module  : div_step
// Purpose : One combinational restoring shift-subtract step.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step
    import mod_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH-1:0] w_shift;
    logic [WIDTH:0]   w_diff;

    assign w_shift = {rem[WIDTH-2:0], dvd_msb};
    assign w_diff  = {1'b0, w_shift} - {1'b0, divisor};

    // rem stays below 2^(WIDTH-1) while dividing; folding its MSB in keeps the compare exact anyway.
    assign q_bit    = rem[WIDTH-1] | ~w_diff[WIDTH];
    assign next_rem = q_bit ? w_diff[WIDTH-1:0] : w_shift;

endmodule

`default_nettype wire

// File: rtl/mod_div_unit.sv
// ============================================================================
// Module  : mod_div_unit
// Purpose : Multi-cycle unsigned divider (quotient + remainder), one bit/cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_div_unit
    import mod_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_by_zero
);

    localparam logic [WIDTH-1:0] c_DBZ_Q    = WIDTH'(DBZ_QUOTIENT(WIDTH));
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_b_zero;

    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_a;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_dbz;

    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_dvd_nxt;
    logic             w_q_bit;

    assign w_b_zero = (B == '0);

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (r_rem),
        .dvd_msb  (r_dvd[WIDTH-1]),
        .divisor  (r_div),
        .next_rem (w_rem_nxt),
        .q_bit    (w_q_bit)
    );

    // The dividend register doubles as the quotient accumulator.
    assign w_dvd_nxt = {r_dvd[WIDTH-2:0], w_q_bit};

    always_ff @(posedge CLK) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b1;
        done        = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept = start;
                if (start) w_state_nxt = w_b_zero ? DONE : RUN;
            end
            RUN: begin
                ready = 1'b0;
                if (r_cnt == '0) w_state_nxt = DONE;
            end
            DONE: begin
                done     = 1'b1;
                w_accept = start;
                if (start) w_state_nxt = w_b_zero ? DONE : RUN;
                else       w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_dvd <= '0;
            r_div <= '0;
            r_rem <= '0;
            r_a   <= '0;
            r_cnt <= '0;
            r_q   <= '0;
            r_r   <= '0;
            r_dbz <= 1'b0;
        end else if (w_accept) begin
            if (w_b_zero) begin
                r_q   <= c_DBZ_Q;
                r_r   <= A;
                r_dbz <= 1'b1;
            end else begin
                r_dvd <= A;
                r_div <= B;
                r_a   <= A;
                r_rem <= '0;
                r_cnt <= c_CNT_LAST;
            end
        end else if (r_state == RUN) begin
            r_dvd <= w_dvd_nxt;
            r_rem <= w_rem_nxt;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
                r_q   <= w_dvd_nxt;
                r_r   <= w_rem_nxt;
                r_dbz <= 1'b0;
            end
        end
    end

    assign Q           = r_q;
    assign R           = r_r;
    assign div_by_zero = r_dbz;

    a_div_invariant: assert property (@(posedge CLK) disable iff (RST)
        (done && !div_by_zero) |->
            ((({{WIDTH{1'b0}}, Q} * {{WIDTH{1'b0}}, r_div}) + {{WIDTH{1'b0}}, R})
                == {{WIDTH{1'b0}}, r_a}) && (R < r_div));

endmodule

`default_nettype wire

// File: tb/tb_mod_div_unit.sv
// ============================================================================
// Module  : tb_mod_div_unit
// Purpose : Self-checking bench for mod_div_unit at WIDTH=32 and WIDTH=8.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_div_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        ready;
    logic        done;
    logic [31:0] Q;
    logic [31:0] R;
    logic        dbz;

    logic        start8;
    logic [7:0]  A8;
    logic [7:0]  B8;
    logic        ready8;
    logic        done8;
    logic [7:0]  Q8;
    logic [7:0]  R8;
    logic        dbz8;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    mod_div_unit #(.WIDTH(32)) dut (
        .CLK(CLK), .RST(RST), .start(start), .A(A), .B(B),
        .ready(ready), .done(done), .Q(Q), .R(R), .div_by_zero(dbz)
    );

    mod_div_unit #(.WIDTH(8)) dut8 (
        .CLK(CLK), .RST(RST), .start(start8), .A(A8), .B(B8),
        .ready(ready8), .done(done8), .Q(Q8), .R(R8), .div_by_zero(dbz8)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Called 1 time unit after an edge; returns cycles from acceptance to done.
    task automatic wait_done32(output int lat);
        lat = 1;
        while (!done && lat < 60) begin
            @(posedge CLK); #1;
            lat++;
        end
        chk("done_seen32", {31'd0, done}, 32'd1);
    endtask

    task automatic op32(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic rdy1);
        A = a; B = b; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        rdy1  = ready;
        wait_done32(lat);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, output int lat);
        A8 = a; B8 = b; start8 = 1'b1;
        @(posedge CLK); #1;
        start8 = 1'b0;
        lat = 1;
        while (!done8 && lat < 30) begin
            @(posedge CLK); #1;
            lat++;
        end
        chk("done_seen8", {31'd0, done8}, 32'd1);
    endtask

    initial begin
        int          lat;
        logic        rdy1;
        logic        seen;
        logic [31:0] ra, rb;
        logic [7:0]  ra8, rb8;

        vecs[0] = '{32'd17,         32'd5,          32'd3,          32'd2,    1'b0};
        vecs[1] = '{32'd5,          32'd17,         32'd0,          32'd5,    1'b0};
        vecs[2] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,    1'b0};
        vecs[3] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,    1'b0};
        vecs[4] = '{32'd1234,       32'd0,          32'hFFFF_FFFF,  32'd1234, 1'b1};
        vecs[5] = '{32'd9,          32'd3,          32'd3,          32'd0,    1'b0};
        vecs[6] = '{32'd0,          32'd7,          32'd0,          32'd0,    1'b0};
        vecs[7] = '{32'd100,        32'd7,          32'd14,         32'd2,    1'b0};
        vecs[8] = '{32'd40,         32'd6,          32'd6,          32'd4,    1'b0};
        vecs[9] = '{32'd1000,       32'd1000,       32'd1,          32'd0,    1'b0};

        RST = 1'b1; start = 1'b0; A = '0; B = '0;
        start8 = 1'b0; A8 = '0; B8 = '0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;

        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done",  {31'd0, done},  32'd0);
        chk("rst_q",     Q,              32'd0);
        chk("rst_r",     R,              32'd0);
        chk("rst_dbz",   {31'd0, dbz},   32'd0);

        for (int i = 0; i < 10; i++) begin
            op32(vecs[i].a, vecs[i].b, lat, rdy1);
            chk($sformatf("v%0d_q", i),     Q,                      vecs[i].q);
            chk($sformatf("v%0d_r", i),     R,                      vecs[i].r);
            chk($sformatf("v%0d_dbz", i),   {31'd0, dbz},           {31'd0, vecs[i].dbz});
            chk($sformatf("v%0d_lat", i),   lat,                    vecs[i].dbz ? 32'd1 : 32'd33);
            chk($sformatf("v%0d_ready", i), {31'd0, rdy1},          {31'd0, vecs[i].dbz});
        end

        @(posedge CLK); #1;
        chk("done_pulse", {31'd0, done}, 32'd0);

        // start pulse mid-run must be ignored
        A = 32'd100; B = 32'd7; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 60) begin
            if (lat == 10) begin
                chk("hold_q_run", Q, vecs[9].q);
                A = 32'd50; B = 32'd5; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge CLK); #1;
            lat++;
        end
        start = 1'b0;
        chk("ign_lat", lat, 32'd33);
        chk("ign_q",   Q,   32'd14);
        chk("ign_r",   R,   32'd2);

        // reset in the middle of an operation
        A = 32'd100; B = 32'd7; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        for (int c = 1; c < 12; c++) begin
            @(posedge CLK); #1;
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk("mrst_q",     Q,              32'd0);
        chk("mrst_r",     R,              32'd0);
        chk("mrst_done",  {31'd0, done},  32'd0);
        chk("mrst_ready", {31'd0, ready}, 32'd1);
        chk("mrst_dbz",   {31'd0, dbz},   32'd0);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge CLK); #1;
            if (done) seen = 1'b1;
        end
        chk("mrst_no_done", {31'd0, seen}, 32'd0);
        op32(32'd9, 32'd4, lat, rdy1);
        chk("post_rst_q",   Q,   32'd2);
        chk("post_rst_r",   R,   32'd1);
        chk("post_rst_lat", lat, 32'd33);

        // back-to-back: start held high through RUN and DONE
        @(posedge CLK); #1;
        A = 32'd17; B = 32'd5; start = 1'b1;
        @(posedge CLK); #1;
        A = 32'd40; B = 32'd6;
        wait_done32(lat);
        chk("b2b1_lat", lat, 32'd33);
        chk("b2b1_q",   Q,   32'd3);
        chk("b2b1_r",   R,   32'd2);
        @(posedge CLK); #1;
        start = 1'b0;
        wait_done32(lat);
        chk("b2b2_lat", lat, 32'd33);
        chk("b2b2_q",   Q,   32'd6);
        chk("b2b2_r",   R,   32'd4);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 0) rb = rb >> 24;
            if (rb == '0) rb = 32'd1;
            op32(ra, rb, lat, rdy1);
            chk("rnd32_q",   Q,   ra / rb);
            chk("rnd32_r",   R,   ra % rb);
            chk("rnd32_lat", lat, 32'd33);
        end

        for (int i = 0; i < 1000; i++) begin
            ra8 = 8'($urandom_range(0, 255));
            rb8 = 8'($urandom_range(1, 255));
            op8(ra8, rb8, lat);
            chk("rnd8_q",   32'(Q8), 32'(ra8 / rb8));
            chk("rnd8_r",   32'(R8), 32'(ra8 % rb8));
            chk("rnd8_lat", lat,     32'd9);
        end

        op8(8'hFF, 8'hFF, lat);
        chk("w8_ones_q", 32'(Q8), 32'd1);
        chk("w8_ones_r", 32'(R8), 32'd0);
        op8(8'd77, 8'd0, lat);
        chk("w8_dbz_q",   32'(Q8),         32'hFF);
        chk("w8_dbz_r",   32'(R8),         32'd77);
        chk("w8_dbz_flag", {31'd0, dbz8},  32'd1);
        chk("w8_dbz_lat", lat,             32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
